// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the div_sched clock-enable scheduler.
// Optional square-wave outputs are enabled by defining SQUARE_OUT_EN.
package div_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIV_W  = 8;

    // The pending struct is sized for the largest supported configuration.
    localparam int MAX_CH_W   = 3;
    localparam int MAX_DIV_W  = 16;

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    typedef struct packed {
        logic [MAX_CH_W-1:0]  ch;
        logic [MAX_DIV_W-1:0] div;
    } pend_t;

endpackage

// File: rtl/div_sched_chan.sv
// One scheduler channel: ratio and counter registers plus output decode.
// clk_out is a real square wave only when SQUARE_OUT_EN is defined.
module div_sched_chan
    import div_sched_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             apply,
    input  logic [DIV_W-1:0] apply_div,
    input  logic             sync,
    output logic             ch_en,
    output logic             clk_out,
    output logic             ch_active
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    // div_q is nonzero whenever the terminal compare matters, so div_q-1 cannot wrap.
    assign ch_active = |div_q;
    assign ch_en     = ch_active && (cnt_q == div_q - DIV_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (apply) begin
            div_q <= apply_div;
            cnt_q <= '0;
        end else if (sync || ch_en || !ch_active) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

`ifdef SQUARE_OUT_EN
    logic [DIV_W-1:0] half_q;

    // ceil(div/2) without widening: floor half plus the dropped LSB.
    assign half_q  = (div_q >> 1) + DIV_W'(div_q[0]);
    assign clk_out = ch_active && (cnt_q < half_q);
`else
    assign clk_out = 1'b0;
`endif

endmodule

// File: rtl/div_sched.sv
// Top of the clock-enable scheduler: config handshake, deferred-update FSM, channels.
// Define SQUARE_OUT_EN to enable the per-channel square-wave outputs.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,   // 2..8
    parameter int DIV_W  = DEF_DIV_W,    // up to MAX_DIV_W
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ch_active,
    output logic              busy
);

    state_t              state;
    pend_t               pend;
    logic                xfer;
    logic                ch_ok;
    logic                imm;
    logic                pend_fire;
    logic [NUM_CH-1:0]   apply_vec;
    logic [DIV_W-1:0]    apply_div;

    // Ready drops combinationally with rst so no transfer is seen during reset.
    assign cfg_ready = (state == IDLE) && !rst;
    assign busy      = (state == PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign ch_ok     = int'(cfg_ch) < NUM_CH;

    // Starting or stopping a channel, or a concurrent sync, has no phase to protect.
    assign imm       = xfer && ch_ok &&
                       (!ch_active[cfg_ch] || (cfg_div == '0) || sync_req);
    assign pend_fire = (state == PEND) &&
                       (ch_en[pend.ch[CH_W-1:0]] || sync_req);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        apply_vec = '0;
        apply_div = cfg_div;
        if (pend_fire) begin
            apply_vec[pend.ch[CH_W-1:0]] = 1'b1;
            apply_div                    = pend.div[DIV_W-1:0];
        end else if (imm) begin
            apply_vec[cfg_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer && ch_ok && !imm) begin
                        pend.ch  <= MAX_CH_W'(cfg_ch);
                        pend.div <= MAX_DIV_W'(cfg_div);
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (pend_fire) begin
                        pend  <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        div_sched_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk_in    (clk_in),
            .rst       (rst),
            .apply     (apply_vec[i]),
            .apply_div (apply_div),
            .sync      (sync_req),
            .ch_en     (ch_en[i]),
            .clk_out   (clk_out[i]),
            .ch_active (ch_active[i])
        );
    end

endmodule
